mac_accumulator: RTL and testbench



---
 rtl/mac_accumulator.sv | 195 +++++++++++++++++++
 tb/tb_mac_accumulator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Pipelined unsigned multiply-accumulate stage: operand register, Wallace-tree
// multiply, product register, dot-product accumulator and a valid/ready result port.

module wallace_mult (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  localparam int W = 16;

  logic [W-1:0] pp [8];

  // 3:2 compressor on whole rows; the carry out of bit 15 is dropped because
  // the exact product always fits in 16 bits, so the reduction stays exact.
  function automatic logic [2*W-1:0] csa(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic [W-1:0] z);
    logic [W-1:0] s;
    logic [W-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = b[i] ? (W'(a) << i) : '0;
  end

  logic [W-1:0] s1a, c1a, s1b, c1b;
  logic [W-1:0] s2a, c2a, s2b, c2b;
  logic [W-1:0] s3, c3;
  logic [W-1:0] s4, c4;

  // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add
  assign {c1a, s1a} = csa(pp[0], pp[1], pp[2]);
  assign {c1b, s1b} = csa(pp[3], pp[4], pp[5]);
  assign {c2a, s2a} = csa(s1a, c1a, s1b);
  assign {c2b, s2b} = csa(c1b, pp[6], pp[7]);
  assign {c3, s3}   = csa(s2a, c2a, s2b);
  assign {c4, s4}   = csa(s3, c3, c2b);

  assign p = s4 + c4;

endmodule

module mac_accumulator #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_count,
  output logic             out_ovf
);

  localparam int DATA_W = 8;
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = 8;

  typedef enum logic {RUN, HOLD} state_t;

  state_t state, state_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    return {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
  endfunction

  logic stall;
  logic accept;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // ---- stage p0: operand register ----
  logic [DATA_W-1:0] x_p0, y_p0;
  logic              last_p0;
  logic              vld_p0;

  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else if (!stall) vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0    <= in_x;
      y_p0    <= in_y;
      last_p0 <= in_last;
    end
  end

  logic [PROD_W-1:0] prod_p0;

  wallace_mult u_mult (
    .a (x_p0),
    .b (y_p0),
    .p (prod_p0)
  );

  // ---- stage p1: product register ----
  logic [PROD_W-1:0] prod_p1;
  logic              last_p1;
  logic              vld_p1;

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else if (!stall) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      prod_p1 <= prod_p0;
      last_p1 <= last_p0;
    end
  end

  // ---- stage p2: accumulator and result register ----
  logic [ACC_W-1:0] acc_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic             ovf_p2;

  logic             acc_en;
  logic             term;
  logic [ACC_W:0]   sum_p2;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;

  assign acc_en  = ~stall & vld_p1;
  assign term    = acc_en & last_p1;
  assign sum_p2  = acc_add(acc_p2, prod_p1);
  assign cnt_nxt = sat_inc(cnt_p2);
  assign ovf_nxt = ovf_p2 | sum_p2[ACC_W];

  // A terminating term restarts the running sum in the same edge it is reported.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p2 <= '0;
      cnt_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (acc_en) begin
      if (last_p1) begin
        acc_p2 <= '0;
        cnt_p2 <= '0;
        ovf_p2 <= 1'b0;
      end else begin
        acc_p2 <= sum_p2[ACC_W-1:0];
        cnt_p2 <= cnt_nxt;
        ovf_p2 <= ovf_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (term) begin
      out_acc   <= sum_p2[ACC_W-1:0];
      out_count <= cnt_nxt;
      out_ovf   <= ovf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // HOLD with out_ready low is a stall, so term cannot fire there.
  always_comb begin
    state_nxt = state;
    out_valid = (state == HOLD);
    case (state)
      RUN:     if (term) state_nxt = HOLD;
      HOLD:    if (out_ready && !term) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed cycle table, hand-written corner sequences,
// and randomized traffic scored against a whole-sum reference model.

module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_last, out_ready;
  logic [7:0]  in_x, in_y;

  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_acc;
  logic [7:0]  out_count;

  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_acc16;
  logic [7:0]  out_count16;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(24)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  mac_accumulator #(.ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .out_valid(out_valid16),
    .out_ready(out_ready), .out_acc(out_acc16), .out_count(out_count16), .out_ovf(out_ovf16)
  );

  typedef struct {
    logic        v;
    logic [7:0]  x, y;
    logic        l, r, ev;
    logic [23:0] ea;
    logic [7:0]  ec;
    logic        eo;
  } vec_t;

  typedef struct {
    logic [23:0] a24;
    logic        o24;
    logic [15:0] a16;
    logic        o16;
    logic [7:0]  c;
  } res_t;

  vec_t tbl[$];
  res_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y,
                       input logic l, input logic r);
    in_valid  = v;
    in_x      = x;
    in_y      = y;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [7:0] x, input logic [7:0] y, input logic l,
                     input logic ev, input logic [23:0] ea, input logic [7:0] ec, input logic eo);
    tbl.push_back('{v, x, y, l, 1'b1, ev, ea, ec, eo});
  endtask

  task automatic score_out();
    res_t e;
    if (exp_q.size() == 0) begin
      chk("rnd_unexpected_result", out_valid, 0);
    end else begin
      e = exp_q.pop_front();
      chk("rnd_acc", out_acc, e.a24);
      chk("rnd_count", out_count, e.c);
      chk("rnd_ovf", out_ovf, e.o24);
      chk("rnd_acc16", out_acc16, e.a16);
      chk("rnd_ovf16", out_ovf16, e.o16);
      chk("rnd_count16", out_count16, e.c);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    longint      cur_sum;
    int          cur_n;
    logic        long_done;
    logic        v, l, r;
    logic [7:0]  x, y;
    res_t        e;

    // directed single-term, back-to-back full-scale, then bubble sums
    add(1,   3,   5, 1, 0, 0, 0, 0);
    add(0,   0,   0, 0, 0, 0, 0, 0);
    add(0,   0,   0, 0, 1, 15, 1, 0);
    add(1, 255, 255, 0, 0, 0, 0, 0);
    add(1, 255, 255, 0, 0, 0, 0, 0);
    add(1, 255, 255, 0, 0, 0, 0, 0);
    add(1, 255, 255, 1, 0, 0, 0, 0);
    add(1,   2,   3, 0, 0, 0, 0, 0);
    add(1,   4,   5, 1, 1, 260100, 4, 0);
    add(0,   0,   0, 0, 0, 0, 0, 0);
    add(0,   0,   0, 0, 1, 26, 2, 0);
    add(0,   0,   0, 0, 0, 0, 0, 0);
    add(1,  10,  10, 0, 0, 0, 0, 0);
    add(0,   0,   0, 0, 0, 0, 0, 0);
    add(0,   0,   0, 0, 0, 0, 0, 0);
    add(0,   0,   0, 0, 0, 0, 0, 0);
    add(1,   0, 200, 0, 0, 0, 0, 0);
    add(0,   0,   0, 0, 0, 0, 0, 0);
    add(1,   1,   6, 1, 0, 0, 0, 0);
    add(0,   0,   0, 0, 0, 0, 0, 0);
    add(0,   0,   0, 0, 1, 106, 3, 0);
    add(0,   0,   0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_acc", out_acc, 0);
    chk("reset_out_count", out_count, 0);
    chk("reset_out_ovf", out_ovf, 0);
    chk("reset_in_ready", in_ready, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].l, tbl[i].r);
      tick();
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_acc", i), out_acc, tbl[i].ea);
        chk($sformatf("tbl%0d_count", i), out_count, tbl[i].ec);
        chk($sformatf("tbl%0d_ovf", i), out_ovf, tbl[i].eo);
      end
    end

    // back-pressure: held result, refused inputs, then one-cycle release
    drive(1, 1, 1, 1, 0); tick();
    chk("bp_valid0", out_valid, 0);
    drive(1, 7, 7, 0, 0); tick();
    drive(1, 1, 2, 1, 0); tick();
    chk("bp_valid1", out_valid, 1);
    chk("bp_acc1", out_acc, 1);
    chk("bp_count1", out_count, 1);
    chk("bp_in_ready_low", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 9, 9, 1, 0); tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_acc", out_acc, 1);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    drive(0, 0, 0, 0, 1); tick();
    chk("bp_taken", out_valid, 0);
    drive(0, 0, 0, 0, 0); tick();
    chk("bp_valid2", out_valid, 1);
    chk("bp_acc2", out_acc, 51);
    chk("bp_count2", out_count, 2);
    tick();
    chk("bp_hold_acc2", out_acc, 51);
    drive(0, 0, 0, 0, 1); tick();
    chk("bp_taken2", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_no_dup", out_valid, 0);
    end

    // overflow on the 16-bit instance, then a clean sum
    drive(1, 255, 255, 0, 1); tick();
    drive(1, 255, 255, 1, 1); tick();
    drive(0, 0, 0, 0, 1); tick();
    tick();
    chk("ovf16_valid", out_valid16, 1);
    chk("ovf16_acc", out_acc16, 64514);
    chk("ovf16_ovf", out_ovf16, 1);
    chk("ovf16_count", out_count16, 2);
    chk("ovf24_acc", out_acc, 130050);
    chk("ovf24_ovf", out_ovf, 0);
    drive(1, 1, 1, 1, 1); tick();
    drive(0, 0, 0, 0, 1); tick();
    tick();
    chk("ovf16_next_valid", out_valid16, 1);
    chk("ovf16_next_acc", out_acc16, 1);
    chk("ovf16_next_ovf", out_ovf16, 0);
    tick();

    // reset drops a pending result
    drive(1, 5, 5, 1, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    tick();
    chk("pend_valid", out_valid, 1);
    chk("pend_acc", out_acc, 25);
    reset = 1'b1; tick();
    chk("pend_reset_valid", out_valid, 0);
    chk("pend_reset_acc", out_acc, 0);
    reset = 1'b0;

    // reset mid-sum discards in-flight terms
    drive(1, 9, 9, 0, 1); tick();
    drive(1, 9, 9, 0, 1); tick();
    chk("rst_mid_valid_a", out_valid, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 1); tick();
    chk("rst_mid_valid_b", out_valid, 0);
    reset = 1'b0;
    chk("rst_mid_in_ready", in_ready, 1);
    drive(1, 2, 2, 1, 1); tick();
    chk("rst_mid_valid_c", out_valid, 0);
    drive(0, 0, 0, 0, 1); tick();
    chk("rst_mid_valid_d", out_valid, 0);
    tick();
    chk("rst_mid_valid", out_valid, 1);
    chk("rst_mid_acc", out_acc, 4);
    chk("rst_mid_count", out_count, 1);
    chk("rst_mid_ovf", out_ovf, 0);
    tick();

    // randomized traffic; the first sum is a 300-term full-scale run
    cur_sum   = 0;
    cur_n     = 0;
    long_done = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!long_done) begin
        v = 1'b1; x = 8'd255; y = 8'd255;
        l = (cur_n == 299);
        r = ($urandom_range(3) != 0);
      end else begin
        v = ($urandom_range(9) < 7);
        x = ($urandom_range(7) == 0) ? 8'd255 : 8'($urandom);
        y = ($urandom_range(7) == 0) ? 8'd255 : 8'($urandom);
        l = ($urandom_range(5) == 0);
        r = ($urandom_range(3) != 0);
      end
      drive(v, x, y, l, r);
      #1;
      chk("rnd_in_ready", in_ready, !(out_valid && !out_ready));
      chk("rnd_in_ready16", in_ready16, !(out_valid16 && !out_ready));
      if (out_valid && out_ready) score_out();
      if (in_valid && in_ready) begin
        cur_sum += longint'(int'(x) * int'(y));
        cur_n++;
        if (l) begin
          e.a24 = cur_sum[23:0];
          e.o24 = (cur_sum > 64'd16777215);
          e.a16 = cur_sum[15:0];
          e.o16 = (cur_sum > 64'd65535);
          e.c   = (cur_n > 255) ? 8'd255 : 8'(cur_n);
          exp_q.push_back(e);
          cur_sum   = 0;
          cur_n     = 0;
          long_done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end

    for (int k = 0; k < 40 && (exp_q.size() != 0); k++) begin
      drive(0, 0, 0, 0, 1);
      #1;
      if (out_valid && out_ready) score_out();
      @(posedge clk);
      #1;
    end
    chk("drain_pending_results", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
